uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller; the next generation of the fixed 8N1 receive path. It takes the asynchronous serial line and produces parallel frames for the CPU side. Frame format is configurable: 5–9 data bits, none/even/odd parity, 1 or 2 stop bits. It contains the baud tick generator, input synchroniser, oversampling receive FSM and a show-ahead FIFO with a valid/ready read port. Per-frame parity and framing status and a sticky overrun flag travel alongside the data.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // FIFO entry is {frame_err, parity_err, data}
    function automatic int unsigned entry_width(input int unsigned data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible whenever not empty.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    // A push into a full FIFO is accepted when the head leaves on the same edge
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: baud tick, line synchroniser, oversampling FSM, overrun flag
// and a show-ahead FIFO carrying {frame_err, parity_err, data} per frame.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_MODE    = 0,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned OVER_SAMPLE    = 16,
    parameter int unsigned BAUDRATE_VALUE = 325,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx_en,
    input  logic                          i_rx_serial,
    output logic [DATA_BITS-1:0]          o_rx_data,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_rx_valid,
    input  logic                          i_rx_ready,
    output logic                          o_rx_done,
    output logic                          o_overrun,
    input  logic                          i_clr_overrun,
    output logic                          o_fifo_empty,
    output logic                          o_fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int unsigned EW = entry_width(DATA_BITS);
    localparam int unsigned TW = (BAUDRATE_VALUE > 0) ? $clog2(BAUDRATE_VALUE + 1) : 1;
    localparam int unsigned SW = $clog2(OVER_SAMPLE);
    localparam logic [TW-1:0] TICK_MAX  = TW'(BAUDRATE_VALUE);
    localparam logic [SW-1:0] HALF_TICK = SW'(OVER_SAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_TICK = SW'(OVER_SAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

    logic [TW-1:0]        r_tick_cnt;
    logic                 w_tick;
    logic [1:0]           r_sync;
    logic                 w_line;
    rx_state_e            r_state, w_state_nx;
    logic [SW-1:0]        r_s_cnt, w_s_cnt_nx;
    logic [3:0]           r_bit_cnt, w_bit_cnt_nx;
    logic [1:0]           r_stop_cnt, w_stop_cnt_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 r_perr, w_perr_nx;
    logic                 r_ferr, w_ferr_nx;
    logic                 r_done, w_done_nx;
    logic                 r_overrun;
    logic [EW-1:0]        w_head;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_drop;

    assign w_tick = (r_tick_cnt == TICK_MAX);
    assign w_line = r_sync[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
            r_sync     <= 2'b11;
            r_state    <= IDLE;
            r_s_cnt    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_sync     <= {r_sync[0], i_rx_serial};
            r_state    <= w_state_nx;
            r_s_cnt    <= w_s_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_shift    <= w_shift_nx;
            r_perr     <= w_perr_nx;
            r_ferr     <= w_ferr_nx;
            r_done     <= w_done_nx;
            // Set has priority over clear
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_s_cnt_nx    = r_s_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_stop_cnt_nx = r_stop_cnt;
        w_shift_nx    = r_shift;
        w_perr_nx     = r_perr;
        w_ferr_nx     = r_ferr;
        w_done_nx     = 1'b0;
        if (r_state != IDLE && !i_rx_en) begin
            w_state_nx = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!w_line && i_rx_en) begin
                        w_state_nx    = START;
                        w_s_cnt_nx    = '0;
                        w_bit_cnt_nx  = '0;
                        w_stop_cnt_nx = '0;
                        w_perr_nx     = 1'b0;
                        w_ferr_nx     = 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_s_cnt == HALF_TICK) begin
                            w_s_cnt_nx = '0;
                            w_state_nx = w_line ? IDLE : DATA;
                        end else begin
                            w_s_cnt_nx = r_s_cnt + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_s_cnt == FULL_TICK) begin
                            w_s_cnt_nx   = '0;
                            w_shift_nx   = {w_line, r_shift[DATA_BITS-1:1]};
                            w_bit_cnt_nx = r_bit_cnt + 4'(1);
                            if (r_bit_cnt == LAST_BIT) begin
                                w_state_nx = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                            end
                        end else begin
                            w_s_cnt_nx = r_s_cnt + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        if (r_s_cnt == FULL_TICK) begin
                            w_s_cnt_nx = '0;
                            w_perr_nx  = ((^r_shift) ^ w_line) != (PARITY_MODE == PAR_ODD);
                            w_state_nx = STOP;
                        end else begin
                            w_s_cnt_nx = r_s_cnt + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_s_cnt == FULL_TICK) begin
                            w_s_cnt_nx    = '0;
                            w_ferr_nx     = r_ferr | !w_line;
                            w_stop_cnt_nx = r_stop_cnt + 2'(1);
                            if (r_stop_cnt == LAST_STOP) begin
                                w_done_nx  = 1'b1;
                                w_state_nx = IDLE;
                            end
                        end else begin
                            w_s_cnt_nx = r_s_cnt + SW'(1);
                        end
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // The push is attempted in the o_rx_done cycle with the final frame status
    assign w_pop  = i_rx_ready && !w_empty;
    assign w_drop = r_done && w_full && !w_pop;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_done),
        .i_data  ({r_ferr, r_perr, r_shift}),
        .i_pop   (i_rx_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (o_fifo_count)
    );

    assign o_rx_data    = w_head[DATA_BITS-1:0];
    assign o_parity_err = w_head[DATA_BITS];
    assign o_frame_err  = w_head[DATA_BITS+1];
    assign o_rx_valid   = !w_empty;
    assign o_fifo_empty = w_empty;
    assign o_fifo_full  = w_full;
    assign o_rx_done    = r_done;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench: an 8N1 receiver (index 0) and a 7O2 receiver (index 1), both with a
// 4-entry FIFO, checked against a frame-level model of the expected entries.
module tb_uart_rx_ctrl;
    localparam int BAUD     = 3;
    localparam int OS       = 16;
    localparam int BIT_CLKS = (BAUD + 1) * OS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ser, en, ready, clr;
    logic [1:0] valid, done, ovr, empty, full;
    logic [2:0] count_a, count_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [1:0] perr, ferr;
    logic [9:0] head_a, head_b;

    int nbits [2] = '{8, 7};
    int pmode [2] = '{0, 2};
    int nstop [2] = '{1, 2};

    int n_chk = 0;
    int n_err = 0;
    int dcnt_a = 0;
    int dcnt_b = 0;
    logic [9:0] qa [$];
    logic [9:0] qb [$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVER_SAMPLE(OS),
        .BAUDRATE_VALUE(BAUD), .FIFO_DEPTH(4)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_en(en[0]), .i_rx_serial(ser[0]),
        .o_rx_data(data_a), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
        .o_rx_valid(valid[0]), .i_rx_ready(ready[0]), .o_rx_done(done[0]),
        .o_overrun(ovr[0]), .i_clr_overrun(clr[0]), .o_fifo_empty(empty[0]),
        .o_fifo_full(full[0]), .o_fifo_count(count_a)
    );

    uart_rx_ctrl #(
        .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVER_SAMPLE(OS),
        .BAUDRATE_VALUE(BAUD), .FIFO_DEPTH(4)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_en(en[1]), .i_rx_serial(ser[1]),
        .o_rx_data(data_b), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
        .o_rx_valid(valid[1]), .i_rx_ready(ready[1]), .o_rx_done(done[1]),
        .o_overrun(ovr[1]), .i_clr_overrun(clr[1]), .o_fifo_empty(empty[1]),
        .o_fifo_full(full[1]), .o_fifo_count(count_b)
    );

    assign head_a = {ferr[0], perr[0], data_a};
    assign head_b = {1'b0, ferr[1], perr[1], data_b};

    always @(posedge clk) begin
        if (done[0]) dcnt_a <= dcnt_a + 1;
        if (done[1]) dcnt_b <= dcnt_b + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [9:0] head_of(input int k);
        return (k == 0) ? head_a : head_b;
    endfunction

    function automatic int count_of(input int k);
        return (k == 0) ? int'(count_a) : int'(count_b);
    endfunction

    function automatic int dcnt_of(input int k);
        return (k == 0) ? dcnt_a : dcnt_b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mask_data(input int k, input logic [8:0] d);
        return d & 9'((1 << nbits[k]) - 1);
    endfunction

    // Parity bit put on the line: correct for the mode unless bad is set
    function automatic logic par_bit(input int k, input logic [8:0] d, input bit bad);
        return (^mask_data(k, d)) ^ (pmode[k] == 2) ^ bad;
    endfunction

    // Expected FIFO entry from what was put on the line
    function automatic logic [9:0] model_entry(input int k, input logic [8:0] d,
                                               input bit bad_par, input int bad_stop);
        logic [8:0] dm;
        logic       pe;
        logic       fe;
        dm = mask_data(k, d);
        pe = 1'b0;
        if (pmode[k] != 0) pe = ((^dm) ^ par_bit(k, d, bad_par)) != (pmode[k] == 2);
        fe = (bad_stop != 0);
        return 10'(dm) | (10'(pe) << nbits[k]) | (10'(fe) << (nbits[k] + 1));
    endfunction

    task automatic model_push(input int k, input logic [9:0] e);
        if (k == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic model_pop(input int k, output logic [9:0] e);
        e = 'x;
        if (k == 0 && qa.size() > 0) e = qa.pop_front();
        if (k == 1 && qb.size() > 0) e = qb.pop_front();
    endtask

    task automatic drive_bit(input int k, input logic b);
        ser[k] = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int k, input logic [8:0] d, input bit bad_par,
                              input int bad_stop);
        drive_bit(k, 1'b0);
        for (int i = 0; i < nbits[k]; i++) drive_bit(k, d[i]);
        if (pmode[k] != 0) drive_bit(k, par_bit(k, d, bad_par));
        for (int s = 1; s <= nstop[k]; s++) drive_bit(k, (bad_stop == s) ? 1'b0 : 1'b1);
    endtask

    task automatic wait_done(input int k, input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done[k]) return;
        end
        check_eq({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic read_check(input int k, input string tag);
        logic [9:0] e;
        model_pop(k, e);
        check_eq({tag, "_valid"}, 32'(valid[k]), 1);
        check_eq({tag, "_entry"}, 32'(head_of(k)), 32'(e));
        ready[k] = 1'b1;
        @(negedge clk);
        ready[k] = 1'b0;
    endtask

    task automatic check_reset_state(input int k, input string tag);
        check_eq({tag, "_valid"}, 32'(valid[k]), 0);
        check_eq({tag, "_empty"}, 32'(empty[k]), 1);
        check_eq({tag, "_full"}, 32'(full[k]), 0);
        check_eq({tag, "_count"}, 32'(count_of(k)), 0);
        check_eq({tag, "_done"}, 32'(done[k]), 0);
        check_eq({tag, "_ovr"}, 32'(ovr[k]), 0);
        check_eq({tag, "_head"}, 32'(head_of(k)), 0);
    endtask

    initial begin
        int         d0;
        logic [8:0] d;
        bit         bp;
        int         bs;
        logic [9:0] e;

        ser = 2'b11; en = 2'b11; ready = 2'b00; clr = 2'b00; rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_state(0, "rst_a");
        check_reset_state(1, "rst_b");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 consumed as soon as it shows up
        ready[0] = 1'b1;
        d0 = dcnt_a;
        fork
            send_frame(0, 9'h0A5, 1'b0, 0);
            begin
                wait_done(0, "a5");
                check_eq("a5_valid_at_done", 32'(valid[0]), 0);
                @(negedge clk);
                check_eq("a5_valid_after", 32'(valid[0]), 1);
                check_eq("a5_entry", 32'(head_a), 32'(model_entry(0, 9'h0A5, 1'b0, 0)));
            end
        join
        ready[0] = 1'b0;
        check_eq("a5_done_cnt", 32'(dcnt_a - d0), 1);
        check_eq("a5_empty", 32'(empty[0]), 1);

        // Random 8N1 frames
        d0 = dcnt_a;
        for (int i = 0; i < 3; i++) begin
            d = 9'($urandom);
            send_frame(0, d, 1'b0, 0);
            model_push(0, model_entry(0, d, 1'b0, 0));
        end
        check_eq("a_rand_done_cnt", 32'(dcnt_a - d0), 3);
        check_eq("a_rand_count", 32'(count_a), 3);
        for (int i = 0; i < 3; i++) read_check(0, $sformatf("a_rand%0d", i));

        // 7O2: bad parity, bad second stop, then random status
        d0 = dcnt_b;
        for (int i = 0; i < 4; i++) begin
            d  = (i < 2) ? 9'h035 : 9'($urandom);
            bp = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            bs = (i == 0) ? 0 : (i == 1) ? 2 : int'($urandom_range(0, 2));
            send_frame(1, d, bp, bs);
            model_push(1, model_entry(1, d, bp, bs));
            // A low final stop bit looks like a new start; discard it
            if (bs == 2) begin
                en[1] = 1'b0;
                repeat (4) @(negedge clk);
                en[1] = 1'b1;
            end
        end
        check_eq("b_done_cnt", 32'(dcnt_b - d0), 4);
        for (int i = 0; i < 4; i++) read_check(1, $sformatf("b_frame%0d", i));

        // False start: 20 clocks low
        d0 = dcnt_a;
        ser[0] = 1'b0;
        repeat (20) @(negedge clk);
        ser[0] = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("fs_done_cnt", 32'(dcnt_a - d0), 0);
        check_eq("fs_empty", 32'(empty[0]), 1);
        send_frame(0, 9'h03C, 1'b0, 0);
        model_push(0, model_entry(0, 9'h03C, 1'b0, 0));
        read_check(0, "fs_next");

        // Overrun: fill, then one more
        for (int i = 1; i <= 4; i++) begin
            send_frame(0, 9'(i), 1'b0, 0);
            model_push(0, model_entry(0, 9'(i), 1'b0, 0));
        end
        check_eq("ovr_pre", 32'(ovr[0]), 0);
        send_frame(0, 9'h005, 1'b0, 0);
        check_eq("ovr_count", 32'(count_a), 4);
        check_eq("ovr_full", 32'(full[0]), 1);
        check_eq("ovr_set", 32'(ovr[0]), 1);

        // Clear in the same cycle as another drop: set wins
        fork
            send_frame(0, 9'h006, 1'b0, 0);
            begin
                wait_done(0, "ovr_clr");
                clr[0] = 1'b1;
                @(negedge clk);
                clr[0] = 1'b0;
                check_eq("ovr_set_wins", 32'(ovr[0]), 1);
            end
        join
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check_eq("ovr_cleared", 32'(ovr[0]), 0);

        // Full FIFO, pop in the push cycle: new entry kept
        fork
            send_frame(0, 9'h007, 1'b0, 0);
            begin
                wait_done(0, "fp");
                model_pop(0, e);
                check_eq("fp_head", 32'(head_a), 32'(e));
                ready[0] = 1'b1;
                @(negedge clk);
                ready[0] = 1'b0;
                check_eq("fp_count", 32'(count_a), 4);
            end
        join
        model_push(0, model_entry(0, 9'h007, 1'b0, 0));
        check_eq("fp_no_ovr", 32'(ovr[0]), 0);
        for (int i = 0; i < 4; i++) read_check(0, $sformatf("fp_read%0d", i));
        check_eq("fp_empty", 32'(empty[0]), 1);

        // Enable dropped mid-frame
        d0 = dcnt_a;
        fork
            send_frame(0, 9'h055, 1'b0, 0);
            begin
                repeat (300) @(negedge clk);
                en[0] = 1'b0;
            end
        join
        en[0] = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("en_done_cnt", 32'(dcnt_a - d0), 0);
        check_eq("en_empty", 32'(empty[0]), 1);

        // Reset mid-frame with one entry held; remaining bits of 0xF8 are all 1
        send_frame(0, 9'h011, 1'b0, 0);
        check_eq("rst2_count_pre", 32'(count_a), 1);
        fork
            send_frame(0, 9'h0F8, 1'b0, 0);
            begin
                repeat (300) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_state(0, "rst2_a");
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        qa.delete();
        qb.delete();
        check_eq("rst2_empty", 32'(empty[0]), 1);
        send_frame(0, 9'h05A, 1'b0, 0);
        model_push(0, model_entry(0, 9'h05A, 1'b0, 0));
        read_check(0, "rst2_next");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
